// File: rtl/mlite_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and the MIPS-lite datapath.
// master = sequencer side, slave = datapath/memory side.
interface mlite_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       rs_neg;
    logic       n_flag;

    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdest;
    logic       reg31;
    logic       link;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready, zero, rs_neg, n_flag,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdest, reg31,
               link, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done,
               illegal, state
    );

    modport slave (
        output opcode, mem_ready, zero, rs_neg, n_flag,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdest, reg31,
               link, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done,
               illegal, state
    );
endinterface

// File: rtl/mlite_multicycle_ctrl.sv
// Multicycle Moore control sequencer for the MIPS-lite datapath.
// Per-state enables are registered from the next state; only the strobes that must react
// to mem_ready or the branch flags in the same cycle are gated combinationally, and those
// are all qualified by the registered state, so reset kills every write at once.
module mlite_multicycle_ctrl #(
    parameter logic [5:0] OP_LW     = 6'b100011,
    parameter logic [5:0] OP_SW     = 6'b101011,
    parameter logic [5:0] OP_BEQ    = 6'b000100,
    parameter logic [5:0] OP_ORI    = 6'b001101,
    parameter logic [5:0] OP_BALN   = 6'b011011,
    parameter logic [5:0] OP_JPC    = 6'b011110,
    parameter logic [5:0] OP_BLTZAL = 6'b100010
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mlite_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRxec   = 4'd7,
        StRwb    = 4'd8,
        StOrix   = 4'd9,
        StOriWb  = 4'd10,
        StBranch = 4'd11,
        StLink   = 4'd12
    } state_e;

    // Moore part of the outputs; done covers the unconditional retire states only.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regdest;
        logic       reg31;
        logic       link;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       done;
    } ctl_t;

    state_e r_state;
    state_e w_next;
    ctl_t   r_ctl;
    ctl_t   w_ctl_nx;

    logic w_is_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_ori;
    logic w_is_baln, w_is_jpc, w_is_bltzal;
    logic w_known, w_link_op, w_taken;

    assign w_is_rtype  = (bus.opcode == 6'b000000);
    assign w_is_lw     = (bus.opcode == OP_LW);
    assign w_is_sw     = (bus.opcode == OP_SW);
    assign w_is_beq    = (bus.opcode == OP_BEQ);
    assign w_is_ori    = (bus.opcode == OP_ORI);
    assign w_is_baln   = (bus.opcode == OP_BALN);
    assign w_is_jpc    = (bus.opcode == OP_JPC);
    assign w_is_bltzal = (bus.opcode == OP_BLTZAL);

    assign w_known   = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_ori |
                       w_is_baln | w_is_jpc | w_is_bltzal;
    assign w_link_op = w_is_baln | w_is_jpc | w_is_bltzal;
    assign w_taken   = (w_is_beq & bus.zero) | (w_is_bltzal & bus.rs_neg) |
                       (w_is_baln & bus.n_flag) | w_is_jpc;

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            StIdle:   w_next = StFetch;
            StFetch:  if (bus.mem_ready) w_next = StDecode;
            StDecode: begin
                if (w_is_rtype)                                  w_next = StRxec;
                else if (w_is_lw | w_is_sw)                      w_next = StMemAdr;
                else if (w_is_ori)                               w_next = StOrix;
                else if (w_is_beq | w_link_op)                   w_next = StBranch;
                else                                             w_next = StFetch;
            end
            StMemAdr: w_next = w_is_sw ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) w_next = StMemWb;
            StMemWb:  w_next = StFetch;
            StMemWr:  if (bus.mem_ready) w_next = StFetch;
            StRxec:   w_next = StRwb;
            StRwb:    w_next = StFetch;
            StOrix:   w_next = StOriWb;
            StOriWb:  w_next = StFetch;
            StBranch: w_next = (w_taken & w_link_op) ? StLink : StFetch;
            StLink:   w_next = StFetch;
            default:  w_next = StIdle;
        endcase
    end

    // Moore enables for the state being entered; opcode is already stable from DECODE on.
    always_comb begin
        w_ctl_nx = '0;
        case (w_next)
            StFetch: begin
                w_ctl_nx.memread = 1'b1;
                w_ctl_nx.alusrcb = 2'b01;
            end
            StDecode: w_ctl_nx.alusrcb = 2'b11;
            StMemAdr: begin
                w_ctl_nx.alusrca = 1'b1;
                w_ctl_nx.alusrcb = 2'b10;
            end
            StMemRd: begin
                w_ctl_nx.memread = 1'b1;
                w_ctl_nx.iord    = 1'b1;
            end
            StMemWb: begin
                w_ctl_nx.regwrite = 1'b1;
                w_ctl_nx.memtoreg = 1'b1;
                w_ctl_nx.done     = 1'b1;
            end
            StMemWr: begin
                w_ctl_nx.memwrite = 1'b1;
                w_ctl_nx.iord     = 1'b1;
            end
            StRxec: begin
                w_ctl_nx.alusrca = 1'b1;
                w_ctl_nx.aluop   = 2'b10;
            end
            StRwb: begin
                w_ctl_nx.regwrite = 1'b1;
                w_ctl_nx.regdest  = 1'b1;
                w_ctl_nx.done     = 1'b1;
            end
            StOrix: begin
                w_ctl_nx.alusrca = 1'b1;
                w_ctl_nx.alusrcb = 2'b10;
                w_ctl_nx.aluop   = 2'b11;
            end
            StOriWb: begin
                w_ctl_nx.regwrite = 1'b1;
                w_ctl_nx.done     = 1'b1;
            end
            StBranch: begin
                w_ctl_nx.alusrca  = 1'b1;
                w_ctl_nx.aluop    = 2'b01;
                w_ctl_nx.pcsource = w_is_jpc ? 2'b10 : 2'b01;
            end
            StLink: begin
                w_ctl_nx.regwrite = 1'b1;
                w_ctl_nx.link     = 1'b1;
                w_ctl_nx.done     = 1'b1;
                w_ctl_nx.reg31    = ~w_is_jpc;
            end
            default: w_ctl_nx = '0;
        endcase
    end

    // State and registered Moore outputs, asynchronously cleared to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= w_ctl_nx;
        end
    end

    assign bus.memread     = r_ctl.memread;
    assign bus.memwrite    = r_ctl.memwrite;
    assign bus.iord        = r_ctl.iord;
    assign bus.regdest     = r_ctl.regdest;
    assign bus.reg31       = r_ctl.reg31;
    assign bus.link        = r_ctl.link;
    assign bus.memtoreg    = r_ctl.memtoreg;
    assign bus.regwrite    = r_ctl.regwrite;
    assign bus.alusrca     = r_ctl.alusrca;
    assign bus.alusrcb     = r_ctl.alusrcb;
    assign bus.aluop       = r_ctl.aluop;
    assign bus.pcsource    = r_ctl.pcsource;
    assign bus.state       = r_state;

    // Same-cycle strobes: fetch completion, branch qualification, retire and illegal.
    assign bus.irwrite     = (r_state == StFetch) & bus.mem_ready;
    assign bus.pcwrite     = (r_state == StFetch) & bus.mem_ready;
    assign bus.pcwritecond = (r_state == StBranch) & w_taken;
    assign bus.instr_done  = r_ctl.done |
                             ((r_state == StMemWr) & bus.mem_ready) |
                             ((r_state == StBranch) & ~(w_taken & w_link_op));
    assign bus.illegal     = (r_state == StDecode) & ~w_known;

endmodule

// File: doc/mlite_multicycle_ctrl.md
Name: mlite_multicycle_ctrl

Overview:
- Multicycle control sequencer for the MIPS-lite datapath. Covers R-type/srl, lw, sw, beq, ori and the custom baln, jpc and bltzal instructions.
- Replaces single-cycle decode with a Moore FSM that issues per-state datapath enables.
- Stalls on a memory ready handshake.
- Sits between the instruction register opcode field, the ALU flags, and the shared instruction/data memory port.

Parameters:
- OP_LW, 6'b100011, lw opcode
- OP_SW, 6'b101011, sw opcode
- OP_BEQ, 6'b000100, beq opcode
- OP_ORI, 6'b001101, ori opcode
- OP_BALN, 6'b011011, baln opcode
- OP_JPC, 6'b011110, jpc opcode
- OP_BLTZAL, 6'b100010, bltzal opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- zero  in  1  ALU zero flag
- rs_neg  in  1  rs[31], sign of rs
- n_flag  in  1  registered status N flag, used by baln
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load qualified inside the block; see Behaviour
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- regdest  out  1  write register select: 1 = rd, 0 = rt
- reg31  out  1  force write register to $31
- link  out  1  register write data = PC (already PC+4)
- memtoreg  out  1  register write data = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct, 11 or
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- instr_done  out  1  one-cycle pulse on instruction retire
- illegal  out  1  one-cycle pulse in DECODE on an unknown opcode
- state  out  4  current state encoding, for debug

Behaviour:
- State register uses asynchronous reset to IDLE (0). In IDLE every output is 0.
- IDLE goes to FETCH unconditionally on the first clock after rst_n rises.
- Outputs are Moore (decoded from state), except the mem_ready-qualified strobes noted below.
- Reset mid-instruction returns to IDLE immediately. No partial writes occur after reset asserts.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RXEC 7, RWB 8, ORIX 9, ORIWB 10, BRANCH 11, LINK 12.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite assert only in the cycle mem_ready=1; the state then goes to DECODE. Otherwise hold in FETCH.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
  - Next state by opcode: 000000 to RXEC; lw/sw to MEMADR; ori to ORIX; beq/baln/jpc/bltzal to BRANCH.
  - Any other opcode: pulse illegal and return to FETCH. instr_done is not pulsed.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdest=0, instr_done=1. Next state FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready; in that cycle instr_done=1, then go to FETCH.
- RXEC: alusrca=1, alusrcb=00, aluop=10. Next state RWB.
- RWB: regwrite=1, regdest=1, instr_done=1. Next state FETCH.
- ORIX: alusrca=1, alusrcb=10, aluop=11. Next state ORIWB.
- ORIWB: regwrite=1, regdest=0, instr_done=1. Next state FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01 for beq/baln/bltzal; pcsource=10 for jpc.
  - The block itself qualifies pcwritecond: it asserts only when the branch is taken.
  - taken = (beq & zero) | (bltzal & rs_neg) | (baln & n_flag) | jpc.
  - Taken baln/jpc/bltzal go to LINK. All other cases pulse instr_done and go to FETCH.
- LINK:
  - regwrite=1, link=1, instr_done=1.
  - reg31=1 for baln/bltzal. reg31=0, regdest=0 for jpc (writes rt).
  - Next state FETCH.
- opcode is sampled combinationally each state; the IR holds it stable from DECODE until the next FETCH.

Test Plan:
- Reset, then an lw with mem_ready low for 2 FETCH cycles and 1 MEMRD cycle → states 0,1,1,1,2,3,4,4,5,1. irwrite/pcwrite are high only in the third FETCH cycle. Retire takes 9 cycles after reset.
- R-type (opcode 0), mem_ready=1 → FETCH, DECODE, RXEC, RWB. regwrite=1, regdest=1 in RWB. instr_done is high exactly 1 cycle.
- beq with zero=0, then with zero=1 → pcwritecond stays 0 in the first case and is 1 in BRANCH in the second. Neither case enters LINK.
- bltzal with rs_neg=1 → BRANCH (pcsource=01) then LINK with reg31=1, link=1. With rs_neg=0 → no LINK and no regwrite.
- jpc → pcsource=10, and LINK writes rt (reg31=0) regardless of flags.
- opcode 6'b111111 → illegal pulses in DECODE, then FETCH. Assert rst_n=0 during MEMWR → state=0 and memwrite=0 immediately, asynchronously.
